// File: rtl/rf_writeback_arbiter.sv
// Shares one register-file write port between the WB stage (priority) and a FIFO-buffered long-latency unit.
// Latency: one cycle from grant to registered regwrite/writereg/writedata; a long result waits at least one cycle in the FIFO.
// Backpressure: l_ready drops when the FIFO is full (registered count); p_ready drops only for a forced anti-starvation grant.
module rf_writeback_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p_valid,
   output logic        p_ready,
   input  logic [4:0]  p_rd,
   input  logic [31:0] p_data,
   input  logic        l_valid,
   output logic        l_ready,
   input  logic [4:0]  l_rd,
   input  logic [31:0] l_data,
   input  logic        alloc_valid,
   input  logic [4:0]  alloc_rd,
   output logic        regwrite,
   output logic [4:0]  writereg,
   output logic [31:0] writedata,
   output logic [31:0] pending
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] LP_DEPTH    = CW'(FIFO_DEPTH);
   localparam logic [WW-1:0] LP_MAX_WAIT = WW'(MAX_WAIT);

   logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
   logic [31:0]   r_fifo_data [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [WW-1:0] r_wait_cnt;
   logic [31:0]   r_pending;
   logic          r_regwrite;
   logic [4:0]    r_writereg;
   logic [31:0]   r_writedata;

   logic          w_nonempty;
   logic          w_force;
   logic          w_grant_l;
   logic          w_grant_p;
   logic          w_push;
   logic [4:0]    w_head_rd;
   logic [31:0]   w_head_data;
   logic [31:0]   w_pending_nxt;

   // Readiness comes from registered state only, so a full FIFO stays not-ready even in a pop cycle.
   assign w_nonempty  = (r_count != '0);
   assign l_ready     = (r_count != LP_DEPTH);
   assign w_push      = l_valid & l_ready;
   assign w_head_rd   = r_fifo_rd[r_rd_ptr];
   assign w_head_data = r_fifo_data[r_rd_ptr];

   // Pipeline wins unless the FIFO head has lost MAX_WAIT times in a row; long unit also takes idle slots.
   assign w_force   = w_nonempty & (r_wait_cnt == LP_MAX_WAIT);
   assign p_ready   = ~w_force;
   assign w_grant_l = w_nonempty & (w_force | ~p_valid);
   assign w_grant_p = p_valid & ~w_force;

   assign regwrite  = r_regwrite;
   assign writereg  = r_writereg;
   assign writedata = r_writedata;
   assign pending   = r_pending;

   // FIFO storage needs no reset: entries are only read while the registered count says they are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wr_ptr]   <= l_rd;
         r_fifo_data[r_wr_ptr] <= l_data;
      end
   end

   // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_grant_l)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_grant_l);
      end
   end

   // Starvation counter: counts consecutive lost cycles of a waiting head, saturating at MAX_WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (!w_nonempty || w_grant_l) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != LP_MAX_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // Scoreboard update: retire the granted head first, then apply the new reservation so set wins.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_grant_l && (w_head_rd != 5'd0))
         w_pending_nxt[w_head_rd] = 1'b0;
      if (alloc_valid && (alloc_rd != 5'd0))
         w_pending_nxt[alloc_rd] = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   // Pending-write scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pending <= '0;
      else
         r_pending <= w_pending_nxt;
   end

   // Registered write port; x0 grants are consumed but never raise regwrite, address/data hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_regwrite  <= 1'b0;
         r_writereg  <= 5'd0;
         r_writedata <= 32'd0;
      end else if (w_grant_l) begin
         r_regwrite  <= (w_head_rd != 5'd0);
         r_writereg  <= w_head_rd;
         r_writedata <= w_head_data;
      end else if (w_grant_p) begin
         r_regwrite  <= (p_rd != 5'd0);
         r_writereg  <= p_rd;
         r_writedata <= p_data;
      end else begin
         r_regwrite  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter with FIFO_DEPTH=2, MAX_WAIT=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled in that same quiet window.
module tb_rf_writeback_arbiter;

   logic        clk;
   logic        rst;
   logic        p_valid;
   logic        p_ready;
   logic [4:0]  p_rd;
   logic [31:0] p_data;
   logic        l_valid;
   logic        l_ready;
   logic [4:0]  l_rd;
   logic [31:0] l_data;
   logic        alloc_valid;
   logic [4:0]  alloc_rd;
   logic        regwrite;
   logic [4:0]  writereg;
   logic [31:0] writedata;
   logic [31:0] pending;

   int ntests = 0;
   int nfail  = 0;

   rf_writeback_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .p_valid(p_valid), .p_ready(p_ready), .p_rd(p_rd), .p_data(p_data),
      .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
      .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      p_valid = 0; p_rd = 0; p_data = 0;
      l_valid = 0; l_rd = 0; l_data = 0;
      alloc_valid = 0; alloc_rd = 0;
      #12;
      // reset state
      chk("rst_regwrite", 32'(regwrite), 32'd0);
      chk("rst_writereg", 32'(writereg), 32'd0);
      chk("rst_writedata", writedata, 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_l_ready", 32'(l_ready), 32'd1);
      chk("rst_p_ready", 32'(p_ready), 32'd1);
      step();
      rst = 1'b0;
      step();

      // pipeline only
      p_valid = 1; p_rd = 5'd3; p_data = 32'hDEADBEEF;
      chk("pipe_p_ready", 32'(p_ready), 32'd1);
      step();
      p_valid = 0;
      chk("pipe_regwrite", 32'(regwrite), 32'd1);
      chk("pipe_writereg", 32'(writereg), 32'd3);
      chk("pipe_writedata", writedata, 32'hDEADBEEF);
      step();
      chk("idle_regwrite", 32'(regwrite), 32'd0);
      chk("idle_hold_reg", 32'(writereg), 32'd3);
      chk("idle_hold_data", writedata, 32'hDEADBEEF);

      // idle-slot drain of a reserved register
      alloc_valid = 1; alloc_rd = 5'd7;
      step();
      alloc_valid = 0;
      chk("alloc7_pending", pending, 32'h0000_0080);
      l_valid = 1; l_rd = 5'd7; l_data = 32'h11;
      chk("drain_l_ready", 32'(l_ready), 32'd1);
      step();
      l_valid = 0;
      chk("drain_no_bypass", 32'(regwrite), 32'd0);
      step();
      chk("drain_regwrite", 32'(regwrite), 32'd1);
      chk("drain_writereg", 32'(writereg), 32'd7);
      chk("drain_writedata", writedata, 32'h11);
      chk("drain_pending", pending, 32'd0);

      // starvation: one FIFO entry vs. a continuously valid pipeline
      alloc_valid = 1; alloc_rd = 5'd10;
      p_valid = 1; p_rd = 5'd1; p_data = 32'h1;
      l_valid = 1; l_rd = 5'd10; l_data = 32'hAA;
      step();
      alloc_valid = 0; l_valid = 0;
      chk("starve_pending", pending, 32'h0000_0400);
      chk("starve_first_pipe", writedata, 32'h1);
      for (int i = 0; i < 4; i++) begin
         p_rd = 5'd2; p_data = 32'(100 + i);
         chk($sformatf("starve_p_ready%0d", i), 32'(p_ready), 32'd1);
         step();
         chk($sformatf("starve_pwrite%0d", i), writedata, 32'(100 + i));
      end
      chk("starve_force", 32'(p_ready), 32'd0);
      step();
      chk("starve_l_regwrite", 32'(regwrite), 32'd1);
      chk("starve_l_writereg", 32'(writereg), 32'd10);
      chk("starve_l_writedata", writedata, 32'hAA);
      chk("starve_pending_clr", pending, 32'd0);
      chk("starve_restart", 32'(p_ready), 32'd1);
      step();
      p_valid = 0;
      chk("starve_p_after", writedata, 32'd103);
      chk("starve_p_after_reg", 32'(writereg), 32'd2);

      // full FIFO
      p_valid = 1; p_rd = 5'd2; p_data = 32'h200;
      l_valid = 1; l_rd = 5'd11; l_data = 32'hB1;
      step();
      l_rd = 5'd12; l_data = 32'hB2;
      chk("full_ready_1", 32'(l_ready), 32'd1);
      step();
      l_rd = 5'd13; l_data = 32'hB3;
      chk("full_ready_0", 32'(l_ready), 32'd0);
      step();
      chk("full_ready_held", 32'(l_ready), 32'd0);
      p_valid = 0;
      chk("full_ready_pop_cycle", 32'(l_ready), 32'd0);
      step();
      chk("full_pop1_reg", 32'(writereg), 32'd11);
      chk("full_pop1_data", writedata, 32'hB1);
      chk("full_ready_after_pop", 32'(l_ready), 32'd1);
      step();
      l_valid = 0;
      chk("full_pop2_reg", 32'(writereg), 32'd12);
      chk("full_pop2_data", writedata, 32'hB2);
      step();
      chk("full_pop3_reg", 32'(writereg), 32'd13);
      chk("full_pop3_data", writedata, 32'hB3);
      chk("full_pop3_we", 32'(regwrite), 32'd1);
      step();
      chk("full_drained", 32'(regwrite), 32'd0);

      // x0 handling
      p_valid = 1; p_rd = 5'd0; p_data = 32'h55;
      l_valid = 1; l_rd = 5'd0; l_data = 32'h66;
      alloc_valid = 1; alloc_rd = 5'd0;
      chk("x0_p_ready", 32'(p_ready), 32'd1);
      step();
      p_valid = 0; l_valid = 0; alloc_valid = 0;
      chk("x0_pipe_we", 32'(regwrite), 32'd0);
      chk("x0_pending", pending, 32'd0);
      step();
      chk("x0_long_we", 32'(regwrite), 32'd0);
      chk("x0_fifo_empty", 32'(l_ready), 32'd1);
      step();
      chk("x0_idle_we", 32'(regwrite), 32'd0);

      // simultaneous reserve and retire of x9
      alloc_valid = 1; alloc_rd = 5'd9;
      step();
      alloc_valid = 0;
      chk("x9_alloc", pending, 32'h0000_0200);
      l_valid = 1; l_rd = 5'd9; l_data = 32'h99;
      step();
      l_valid = 0;
      alloc_valid = 1; alloc_rd = 5'd9;
      step();
      alloc_valid = 0;
      chk("x9_write_reg", 32'(writereg), 32'd9);
      chk("x9_write_we", 32'(regwrite), 32'd1);
      chk("x9_set_wins", pending, 32'h0000_0200);
      alloc_valid = 1; alloc_rd = 5'd9;
      step();
      alloc_valid = 0;
      chk("x9_realloc", pending, 32'h0000_0200);
      l_valid = 1; l_rd = 5'd9; l_data = 32'h9A;
      step();
      l_valid = 0;
      step();
      chk("x9_retire", pending, 32'd0);

      // reset mid-stream
      p_valid = 1; p_rd = 5'd4; p_data = 32'h44;
      l_valid = 1; l_rd = 5'd20; l_data = 32'hC0;
      alloc_valid = 1; alloc_rd = 5'd5;
      step();
      alloc_valid = 0;
      l_rd = 5'd21; l_data = 32'hC1;
      step();
      l_valid = 0; p_valid = 0;
      chk("mid_pre_full", 32'(l_ready), 32'd0);
      chk("mid_pre_pending", pending, 32'h0000_0020);
      rst = 1'b1;
      #1;
      chk("mid_rst_pending", pending, 32'd0);
      chk("mid_rst_l_ready", 32'(l_ready), 32'd1);
      chk("mid_rst_regwrite", 32'(regwrite), 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("mid_no_write%0d", i), 32'(regwrite), 32'd0);
      end
      chk("mid_end_pending", pending, 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
